letc_core_pipe_ctrl: RTL and testbench
======================================

Name: letc_core_pipe_ctrl

Overview:
Parametrised pipeline hazard and redirect controller for the LETC Core, sized by stage count.
- Generates per-stage stall/flush vectors from per-stage ready/valid.
- Drives the fetch PC load port on taken branches.
- Sequences interrupt entry: flush the younger stages, drain the older stages, redirect to mtvec with a latched cause and EPC.
- Sits between the pipeline stages and fetch1, in place of ad-hoc glue.

Parameters:
NUM_STAGES, 7, number of pipeline stages; index 0 = fetch1, NUM_STAGES-1 = writeback
REDIRECT_STAGE, 3, stage that resolves branches; stages below it are younger and flushable
CNT_W, 32, width of the saturating stall-cycle counter

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
stage_ready  in  NUM_STAGES  bit i = 0: stage i cannot advance this cycle
stage_valid  in  NUM_STAGES  bit i = 1: stage i holds a valid instruction
branch_taken  in  1  branch resolved taken in REDIRECT_STAGE
branch_target  in  32  target PC of taken branch
oldest_young_pc  in  32  PC of the instruction in stage REDIRECT_STAGE-1
timer_irq_pending  in  1  machine timer interrupt pending
external_irq_pending  in  1  machine external interrupt pending
irq_enable  in  1  global AND per-source enable (mstatus.MIE, already masked)
mtvec  in  32  trap vector CSR value
stage_stall  out  NUM_STAGES  hold stage i
stage_flush  out  NUM_STAGES  invalidate stage i contents
pc_load_en  out  1  load fetch PC this cycle
pc_load_val  out  32  PC to load
irq_taken  out  1  one-cycle pulse on interrupt redirect
irq_cause  out  4  latched interrupt cause (7 timer, 11 external)
irq_epc  out  32  latched EPC for mepc write
busy  out  1  state != RUN
stall_cnt  out  CNT_W  saturating count of cycles with stage_stall[0]=1

Behaviour:
Reset (async, rst_n=0):
- state=RUN; irq_cause=0; irq_epc=0; stall_cnt=0.
- irq_taken=0; pc_load_en=0; pc_load_val=0.
- stage_stall=0; stage_flush all ones.

Stall, in all states:
- base_stall[i] = |(~stage_ready[NUM_STAGES-1:i]).
- Output stall is base_stall plus the state overrides below.

FSM RUN, DRAIN, REDIRECT:
RUN:
- If branch_taken and !stage_stall[REDIRECT_STAGE]: stage_flush[REDIRECT_STAGE-1:0]=1, pc_load_en=1, pc_load_val=branch_target, same cycle (combinational).
- irq_req = irq_enable & (timer_irq_pending | external_irq_pending).
- If irq_req: go to DRAIN next cycle.
  - Latch cause: external=11 has priority over timer=7.
  - Latch irq_epc = branch_target if a branch is taken this cycle, else oldest_young_pc.
  - The branch flush/load above still occurs that cycle.
DRAIN:
- stage_flush[REDIRECT_STAGE-1:0]=1 and stage_stall[0]=1 every cycle; pc_load_en=0.
- branch_taken (older instruction) overwrites irq_epc with branch_target.
- Exit to REDIRECT when stage_valid[NUM_STAGES-1:REDIRECT_STAGE]==0, evaluated combinationally.
  - If already 0 on the entry cycle, DRAIN lasts exactly 1 cycle.
- Deassertion of the irq inputs is ignored once DRAIN is entered.
REDIRECT, one cycle, then RUN:
- pc_load_en=1; irq_taken=1; stage_flush[REDIRECT_STAGE-1:0]=1.
- pc_load_val = {mtvec[31:2],2'b00}, plus (irq_cause<<2) if mtvec[1:0]==2'b01.
- mtvec[1:0] of 2'b10 or 2'b11 is treated as direct.
- A new irq_req is not sampled until the following RUN cycle.
- busy=1 in DRAIN and REDIRECT.

stall_cnt:
- Increments when stage_stall[0]=1.
- Saturates at all ones; no wrap.

Reset asserted mid-DRAIN or mid-REDIRECT: immediately back to RUN with reset values; no irq_taken pulse.

Static checks:
- NUM_STAGES >= 3.
- 1 <= REDIRECT_STAGE < NUM_STAGES.
- Elaboration error otherwise.

Test Plan:
1. Reset, then stage_ready=7'h7F, no events -> stall=0, flush=0, pc_load_en=0, stall_cnt stays 0.
2. stage_ready[5]=0 for 4 cycles -> stage_stall=7'h3F for those cycles; stall_cnt=4 afterwards.
3. branch_taken=1, branch_target=0x8000_0100, no stall -> same cycle flush=7'h07, pc_load_en=1, pc_load_val=0x8000_0100; state remains RUN.
4. Timer irq, irq_enable=1, mtvec=0x8000_0000, oldest_young_pc=0x8000_0040, stage_valid[6:3] clears 3 cycles later:
   - DRAIN for 3 cycles: flush=7'h07, stall[0]=1.
   - REDIRECT: pc_load_val=0x8000_0000, irq_cause=7, irq_epc=0x8000_0040, irq_taken for 1 cycle.
5. Both irqs pending, mtvec=0x8000_0001, branch to 0x8000_0200 during DRAIN -> irq_cause=11, irq_epc=0x8000_0200, pc_load_val=0x8000_002C.
6. rst_n low in the second DRAIN cycle -> outputs at reset values at once, no irq_taken; after release, state=RUN.

Source files
------------

// File: rtl/letc_core_pipe_ctrl_if.sv
// Handshake and control bundle between the pipeline stages, fetch1 and the
// pipeline controller.
interface letc_core_pipe_ctrl_if #(
  parameter int unsigned NUM_STAGES = 7,
  parameter int unsigned CNT_W      = 32
);
  logic [NUM_STAGES-1:0] stage_ready;
  logic [NUM_STAGES-1:0] stage_valid;
  logic                  branch_taken;
  logic [31:0]           branch_target;
  logic [31:0]           oldest_young_pc;
  logic                  timer_irq_pending;
  logic                  external_irq_pending;
  logic                  irq_enable;
  logic [31:0]           mtvec;

  logic [NUM_STAGES-1:0] stage_stall;
  logic [NUM_STAGES-1:0] stage_flush;
  logic                  pc_load_en;
  logic [31:0]           pc_load_val;
  logic                  irq_taken;
  logic [3:0]            irq_cause;
  logic [31:0]           irq_epc;
  logic                  busy;
  logic [CNT_W-1:0]      stall_cnt;

  // Pipeline / CSR side
  modport master (
    output stage_ready, stage_valid, branch_taken, branch_target, oldest_young_pc,
           timer_irq_pending, external_irq_pending, irq_enable, mtvec,
    input  stage_stall, stage_flush, pc_load_en, pc_load_val, irq_taken, irq_cause,
           irq_epc, busy, stall_cnt
  );

  // Controller side
  modport slave (
    input  stage_ready, stage_valid, branch_taken, branch_target, oldest_young_pc,
           timer_irq_pending, external_irq_pending, irq_enable, mtvec,
    output stage_stall, stage_flush, pc_load_en, pc_load_val, irq_taken, irq_cause,
           irq_epc, busy, stall_cnt
  );
endinterface

// File: rtl/letc_core_pipe_ctrl.sv
// Pipeline hazard and redirect controller: per-stage stall/flush, branch PC
// redirect and interrupt entry sequencing (flush young, drain old, vector).
module letc_core_pipe_ctrl #(
  parameter int unsigned NUM_STAGES     = 7,
  parameter int unsigned REDIRECT_STAGE = 3,
  parameter int unsigned CNT_W          = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  letc_core_pipe_ctrl_if.slave bus
);

  if (NUM_STAGES < 3) begin : gen_bad_num_stages
    $error("letc_core_pipe_ctrl: NUM_STAGES must be >= 3");
  end
  if (REDIRECT_STAGE < 1 || REDIRECT_STAGE >= NUM_STAGES) begin : gen_bad_redirect_stage
    $error("letc_core_pipe_ctrl: REDIRECT_STAGE must be in [1, NUM_STAGES)");
  end

  localparam logic [NUM_STAGES-1:0] YoungMask =
      {NUM_STAGES{1'b1}} >> (NUM_STAGES - REDIRECT_STAGE);

  localparam logic [3:0] CauseTimer    = 4'd7;
  localparam logic [3:0] CauseExternal = 4'd11;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StRedirect
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       cause_q, cause_d;
  logic [31:0]      epc_q, epc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NUM_STAGES-1:0] base_stall;
  logic [NUM_STAGES-1:0] stall;
  logic [NUM_STAGES-1:0] flush;
  logic                  pc_load_en;
  logic [31:0]           pc_load_val;
  logic                  irq_taken;
  logic                  irq_req;
  logic                  branch_go;
  logic                  older_valid;
  logic [31:0]           vec_base;
  logic [31:0]           vec_off;

  // A stage must hold if it or any older stage cannot advance.
  always_comb begin
    base_stall = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      base_stall[i] = |((~bus.stage_ready) >> i);
    end
  end

  assign irq_req     = bus.irq_enable & (bus.timer_irq_pending | bus.external_irq_pending);
  assign branch_go   = bus.branch_taken & ~base_stall[REDIRECT_STAGE];
  assign older_valid = |(bus.stage_valid & ~YoungMask);
  assign vec_base    = {bus.mtvec[31:2], 2'b00};
  assign vec_off     = (bus.mtvec[1:0] == 2'b01) ? {26'd0, cause_q, 2'b00} : 32'd0;

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    epc_d       = epc_q;
    stall       = base_stall;
    flush       = '0;
    pc_load_en  = 1'b0;
    pc_load_val = 32'd0;
    irq_taken   = 1'b0;

    unique case (state_q)
      StRun: begin
        if (branch_go) begin
          flush       = YoungMask;
          pc_load_en  = 1'b1;
          pc_load_val = bus.branch_target;
        end
        if (irq_req) begin
          state_d = StDrain;
          cause_d = bus.external_irq_pending ? CauseExternal : CauseTimer;
          epc_d   = branch_go ? bus.branch_target : bus.oldest_young_pc;
        end
      end
      StDrain: begin
        flush    = YoungMask;
        stall[0] = 1'b1;
        // An older branch still retiring moves the return point.
        if (bus.branch_taken) begin
          epc_d = bus.branch_target;
        end
        if (!older_valid) begin
          state_d = StRedirect;
        end
      end
      StRedirect: begin
        flush       = YoungMask;
        pc_load_en  = 1'b1;
        pc_load_val = vec_base + vec_off;
        irq_taken   = 1'b1;
        state_d     = StRun;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall[0] && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      cause_q <= 4'd0;
      epc_q   <= 32'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Combinational outputs are forced to their reset values while reset is held.
  assign bus.stage_stall = rst_n ? stall : '0;
  assign bus.stage_flush = rst_n ? flush : '1;
  assign bus.pc_load_en  = rst_n & pc_load_en;
  assign bus.pc_load_val = rst_n ? pc_load_val : 32'd0;
  assign bus.irq_taken   = rst_n & irq_taken;
  assign bus.irq_cause   = cause_q;
  assign bus.irq_epc     = epc_q;
  assign bus.busy        = (state_q != StRun);
  assign bus.stall_cnt   = cnt_q;

endmodule

// File: tb/tb_letc_core_pipe_ctrl.sv
// Scoreboard bench for letc_core_pipe_ctrl: each cycle's expected outputs are
// queued as stimulus is driven and compared mid-cycle.
module tb_letc_core_pipe_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  letc_core_pipe_ctrl_if #(.NUM_STAGES(7), .CNT_W(32)) bus ();

  letc_core_pipe_ctrl #(
    .NUM_STAGES(7),
    .REDIRECT_STAGE(3),
    .CNT_W(32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    string       tag;
    logic [6:0]  stall;
    logic [6:0]  flush;
    logic        ld;
    logic [31:0] ldval;
    logic        irqt;
    logic        busy;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned m_cnt    = 0;
  logic [3:0]  m_cause  = 4'd0;
  logic [31:0] m_epc    = 32'd0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic [6:0] stall, input logic [6:0] flush,
                              input logic ld, input logic [31:0] ldval, input logic irqt,
                              input logic busy);
    exp_t e;
    e.tag = tag; e.stall = stall; e.flush = flush; e.ld = ld;
    e.ldval = ldval; e.irqt = irqt; e.busy = busy;
    return e;
  endfunction

  // Inputs for the cycle are already driven; queue expectation, let logic settle, compare.
  task automatic step(input exp_t e);
    exp_t o;
    sb_q.push_back(e);
    #4;
    o = sb_q.pop_front();
    check_eq({o.tag, ".stall"}, 64'(bus.stage_stall), 64'(o.stall));
    check_eq({o.tag, ".flush"}, 64'(bus.stage_flush), 64'(o.flush));
    check_eq({o.tag, ".ld_en"}, 64'(bus.pc_load_en), 64'(o.ld));
    check_eq({o.tag, ".ld_val"}, 64'(bus.pc_load_val), 64'(o.ldval));
    check_eq({o.tag, ".irq_taken"}, 64'(bus.irq_taken), 64'(o.irqt));
    check_eq({o.tag, ".busy"}, 64'(bus.busy), 64'(o.busy));
    check_eq({o.tag, ".cause"}, 64'(bus.irq_cause), 64'(m_cause));
    check_eq({o.tag, ".epc"}, 64'(bus.irq_epc), 64'(m_epc));
    check_eq({o.tag, ".cnt"}, 64'(bus.stall_cnt), 64'(m_cnt));
    if (rst_n && o.stall[0]) m_cnt++;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stage_ready          = 7'h7F;
    bus.stage_valid          = 7'h00;
    bus.branch_taken         = 1'b0;
    bus.branch_target        = 32'd0;
    bus.oldest_young_pc      = 32'd0;
    bus.timer_irq_pending    = 1'b0;
    bus.external_irq_pending = 1'b0;
    bus.irq_enable           = 1'b0;
    bus.mtvec                = 32'd0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    // Reset with hostile inputs: outputs must still show reset values.
    bus.stage_ready   = 7'h00;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h1234_5678;
    #2;
    step(mk("reset", 7'h00, 7'h7F, 1'b0, 32'd0, 1'b0, 1'b0));

    next_cycle();
    idle_inputs();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(mk("idle", 7'h00, 7'h00, 1'b0, 32'd0, 1'b0, 1'b0));
      next_cycle();
    end

    // Stage 5 back-pressure for 4 cycles.
    bus.stage_ready = 7'h5F;
    for (int i = 0; i < 4; i++) begin
      step(mk("stall5", 7'h3F, 7'h00, 1'b0, 32'd0, 1'b0, 1'b0));
      next_cycle();
    end
    bus.stage_ready = 7'h7F;
    step(mk("stall5_end", 7'h00, 7'h00, 1'b0, 32'd0, 1'b0, 1'b0));

    // Taken branch, unstalled.
    next_cycle();
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h8000_0100;
    step(mk("branch", 7'h00, 7'h07, 1'b1, 32'h8000_0100, 1'b0, 1'b0));
    next_cycle();
    bus.branch_taken = 1'b0;
    step(mk("branch_after", 7'h00, 7'h00, 1'b0, 32'd0, 1'b0, 1'b0));

    // Branch while the redirect stage is stalled is held off.
    next_cycle();
    bus.branch_taken = 1'b1;
    bus.stage_ready  = 7'h6F;
    step(mk("branch_stalled", 7'h1F, 7'h00, 1'b0, 32'd0, 1'b0, 1'b0));
    next_cycle();
    idle_inputs();

    // Pending irq with enable low is ignored.
    bus.timer_irq_pending = 1'b1;
    step(mk("irq_masked", 7'h00, 7'h00, 1'b0, 32'd0, 1'b0, 1'b0));
    next_cycle();

    // Timer irq, direct vector, older stages drain over 3 cycles.
    bus.irq_enable      = 1'b1;
    bus.mtvec           = 32'h8000_0000;
    bus.oldest_young_pc = 32'h8000_0040;
    bus.stage_valid     = 7'h78;
    step(mk("tmr_run", 7'h00, 7'h00, 1'b0, 32'd0, 1'b0, 1'b0));
    m_cause = 4'd7;
    m_epc   = 32'h8000_0040;
    next_cycle();
    bus.timer_irq_pending = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) bus.stage_valid = 7'h00;
      step(mk("tmr_drain", 7'h01, 7'h07, 1'b0, 32'd0, 1'b0, 1'b1));
      next_cycle();
    end
    step(mk("tmr_redir", 7'h00, 7'h07, 1'b1, 32'h8000_0000, 1'b1, 1'b1));
    next_cycle();
    step(mk("tmr_back", 7'h00, 7'h00, 1'b0, 32'd0, 1'b0, 1'b0));

    // Both irqs, vectored, older branch during drain moves the EPC.
    next_cycle();
    bus.timer_irq_pending    = 1'b1;
    bus.external_irq_pending = 1'b1;
    bus.mtvec                = 32'h8000_0001;
    bus.stage_valid          = 7'h78;
    step(mk("ext_run", 7'h00, 7'h00, 1'b0, 32'd0, 1'b0, 1'b0));
    m_cause = 4'd11;
    m_epc   = 32'h8000_0040;
    next_cycle();
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h8000_0200;
    step(mk("ext_drain1", 7'h01, 7'h07, 1'b0, 32'd0, 1'b0, 1'b1));
    m_epc = 32'h8000_0200;
    next_cycle();
    bus.branch_taken = 1'b0;
    bus.stage_valid  = 7'h00;
    step(mk("ext_drain2", 7'h01, 7'h07, 1'b0, 32'd0, 1'b0, 1'b1));
    next_cycle();
    // irqs stay pending in REDIRECT but must not be sampled there.
    step(mk("ext_redir", 7'h00, 7'h07, 1'b1, 32'h8000_002C, 1'b1, 1'b1));
    next_cycle();
    bus.timer_irq_pending    = 1'b0;
    bus.external_irq_pending = 1'b0;
    step(mk("ext_back", 7'h00, 7'h00, 1'b0, 32'd0, 1'b0, 1'b0));

    // mtvec mode 2'b11 is direct; older stages already empty -> 1-cycle drain.
    next_cycle();
    bus.timer_irq_pending = 1'b1;
    bus.mtvec             = 32'h8000_0003;
    bus.oldest_young_pc   = 32'h8000_0080;
    step(mk("m3_run", 7'h00, 7'h00, 1'b0, 32'd0, 1'b0, 1'b0));
    m_cause = 4'd7;
    m_epc   = 32'h8000_0080;
    next_cycle();
    bus.timer_irq_pending = 1'b0;
    step(mk("m3_drain", 7'h01, 7'h07, 1'b0, 32'd0, 1'b0, 1'b1));
    next_cycle();
    step(mk("m3_redir", 7'h00, 7'h07, 1'b1, 32'h8000_0000, 1'b1, 1'b1));
    next_cycle();
    step(mk("m3_back", 7'h00, 7'h00, 1'b0, 32'd0, 1'b0, 1'b0));

    // Reset in the second drain cycle.
    next_cycle();
    bus.timer_irq_pending = 1'b1;
    bus.stage_valid       = 7'h78;
    step(mk("rd_run", 7'h00, 7'h00, 1'b0, 32'd0, 1'b0, 1'b0));
    next_cycle();
    bus.timer_irq_pending = 1'b0;
    step(mk("rd_drain1", 7'h01, 7'h07, 1'b0, 32'd0, 1'b0, 1'b1));
    next_cycle();
    rst_n   = 1'b0;
    m_cause = 4'd0;
    m_epc   = 32'd0;
    m_cnt   = 0;
    step(mk("rd_reset", 7'h00, 7'h7F, 1'b0, 32'd0, 1'b0, 1'b0));
    next_cycle();
    rst_n = 1'b1;
    bus.stage_valid = 7'h00;
    step(mk("rd_after", 7'h00, 7'h00, 1'b0, 32'd0, 1'b0, 1'b0));
    next_cycle();
    step(mk("rd_after2", 7'h00, 7'h00, 1'b0, 32'd0, 1'b0, 1'b0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
